iob_master: RTL



---
 rtl/iob_master_pkg.sv | 26 ++
 rtl/iob_eclk.sv | 23 ++
 rtl/iob_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/iob_master_pkg.sv
// iob_master_pkg: shared state encoding and default legacy bus timing
package iob_master_pkg;

    localparam int E_PERIOD_DEF = 10;
    localparam int E_HIGH_DEF   = 4;
    localparam int VMA_SLOT_DEF = 2;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_AS,
        ST_DS,
        ST_WAIT,
        ST_VSYNC,
        ST_VHOLD,
        ST_LATCH,
        ST_END,
        ST_RECOV
    } state_t;

    // E count one clock before the given count, so a registered action lands on it
    function automatic int ecount_before(input int count, input int period);
        return (count + period - 1) % period;
    endfunction

endpackage

// File: rtl/iob_eclk.sv
// iob_eclk: free-running 6800 E clock generator with count output
module iob_eclk
    import iob_master_pkg::*;
#(
    parameter int E_PERIOD = E_PERIOD_DEF,
    parameter int E_HIGH   = E_HIGH_DEF,
    localparam int EW      = $clog2(E_PERIOD)
) (
    input  logic          CLK,
    input  logic          nRST,
    output logic [EW-1:0] ecount,
    output logic          Eout
);

    // count 0..E_PERIOD-1 and wrap, independent of any bus activity
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ecount <= '0;
        else       ecount <= (ecount == EW'(E_PERIOD - 1)) ? '0 : ecount + EW'(1);
    end

    assign Eout = ecount >= EW'(E_PERIOD - E_HIGH);

endmodule

// File: rtl/iob_master.sv
// iob_master: runs one 68000-style (or 6800 VPA) bus cycle per bridge request
module iob_master
    import iob_master_pkg::*;
#(
    parameter int E_PERIOD = E_PERIOD_DEF,
    parameter int E_HIGH   = E_HIGH_DEF,
    parameter int VMA_SLOT = VMA_SLOT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic IOREQ,
    input  logic IORW0,
    input  logic IOL0,
    input  logic IOU0,
    output logic IOACT,
    output logic IOBERR,
    output logic nASout,
    output logic nLDSout,
    output logic nUDSout,
    output logic RnWout,
    output logic nDoutOE,
    output logic DinLE,
    output logic nVMAout,
    output logic Eout,
    input  logic nDTACK,
    input  logic nVPA,
    input  logic nBERR
);

    localparam int EW        = $clog2(E_PERIOD);
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int VMA_PRE   = ecount_before(VMA_SLOT, E_PERIOD);
    localparam int LATCH_PRE = ecount_before(E_PERIOD - 1, E_PERIOD);

    state_t        state, state_d;
    logic [EW-1:0] ecount;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          ioreq_r, dtack_r, vpa_r, berr_r;
    logic          armed, armed_d;
    logic          rw, rw_d, lo, lo_d, up, up_d;
    logic          ioact_d, ioberr_d, nas_d, nlds_d, nuds_d, rnw_d, ndoe_d, dinle_d, nvma_d;

    iob_eclk #(
        .E_PERIOD (E_PERIOD),
        .E_HIGH   (E_HIGH)
    ) u_eclk (
        .CLK    (CLK),
        .nRST   (nRST),
        .ecount (ecount),
        .Eout   (Eout)
    );

    // single-register synchronizers; bus responses become active-high
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ioreq_r <= 1'b0;
            dtack_r <= 1'b0;
            vpa_r   <= 1'b0;
            berr_r  <= 1'b0;
        end else begin
            ioreq_r <= IOREQ;
            dtack_r <= ~nDTACK;
            vpa_r   <= ~nVPA;
            berr_r  <= ~nBERR;
        end
    end

    // next state and next values of every registered bus output;
    // VPA waits compare one count early so nVMA and DinLE coincide with the named E count
    always_comb begin
        state_d  = state;
        tcnt_d   = tcnt;
        armed_d  = armed | ~ioreq_r;
        rw_d     = rw;
        lo_d     = lo;
        up_d     = up;
        ioact_d  = IOACT;
        ioberr_d = IOBERR;
        nas_d    = nASout;
        nlds_d   = nLDSout;
        nuds_d   = nUDSout;
        rnw_d    = RnWout;
        ndoe_d   = nDoutOE;
        dinle_d  = 1'b0;
        nvma_d   = nVMAout;
        case (state)
            ST_IDLE: if (ioreq_r && armed) begin
                ioact_d  = 1'b1;
                ioberr_d = 1'b0;
                armed_d  = 1'b0;
                rw_d     = IORW0;
                lo_d     = IOL0;
                up_d     = IOU0;
                rnw_d    = IORW0;
                ndoe_d   = IORW0;
                state_d  = ST_AS;
            end
            ST_AS: begin
                nas_d   = 1'b0;
                nlds_d  = rw ? ~lo : nLDSout;
                nuds_d  = rw ? ~up : nUDSout;
                state_d = ST_DS;
            end
            ST_DS: begin
                nlds_d  = rw ? nLDSout : ~lo;
                nuds_d  = rw ? nUDSout : ~up;
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (berr_r) begin
                    ioberr_d = 1'b1;
                    state_d  = ST_END;
                end else if (dtack_r) begin
                    dinle_d = 1'b1;
                    state_d = ST_LATCH;
                end else if (vpa_r) begin
                    state_d = ST_VSYNC;
                end else if (tcnt == TW'(TIMEOUT)) begin
                    ioberr_d = 1'b1;
                    state_d  = ST_END;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            ST_VSYNC: if (ecount == EW'(VMA_PRE)) begin
                nvma_d  = 1'b0;
                state_d = ST_VHOLD;
            end
            ST_VHOLD: if (ecount == EW'(LATCH_PRE)) begin
                dinle_d = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: state_d = ST_END;
            ST_END: begin
                nas_d   = 1'b1;
                nlds_d  = 1'b1;
                nuds_d  = 1'b1;
                nvma_d  = 1'b1;
                ndoe_d  = 1'b1;
                rnw_d   = 1'b1;
                state_d = ST_RECOV;
            end
            ST_RECOV: begin
                ioact_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers; reset drops every strobe without a handshake
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            tcnt    <= '0;
            armed   <= 1'b1;
            rw      <= 1'b1;
            lo      <= 1'b0;
            up      <= 1'b0;
            IOACT   <= 1'b0;
            IOBERR  <= 1'b0;
            nASout  <= 1'b1;
            nLDSout <= 1'b1;
            nUDSout <= 1'b1;
            RnWout  <= 1'b1;
            nDoutOE <= 1'b1;
            DinLE   <= 1'b0;
            nVMAout <= 1'b1;
        end else begin
            state   <= state_d;
            tcnt    <= tcnt_d;
            armed   <= armed_d;
            rw      <= rw_d;
            lo      <= lo_d;
            up      <= up_d;
            IOACT   <= ioact_d;
            IOBERR  <= ioberr_d;
            nASout  <= nas_d;
            nLDSout <= nlds_d;
            nUDSout <= nuds_d;
            RnWout  <= rnw_d;
            nDoutOE <= ndoe_d;
            DinLE   <= dinle_d;
            nVMAout <= nvma_d;
        end
    end

endmodule
